// File: rtl/ex_div_pkg.sv
// Shared definitions for the EX-stage iterative divider.
package ex_div_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam int unsigned DivCntW = 6;

endpackage

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU; one quotient bit per cycle,
// result returned as {remainder, quotient} for HI/LO.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam logic [DivCntW-1:0] CntLast = DivCntW'(WIDTH - 1);

    div_state_e         state_q, state_d;
    logic [DivCntW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic               signed_q, signed_d;
    logic               sign1_q, sign1_d;
    logic               sign2_q, sign2_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]   abs1, abs2;
    logic [WIDTH:0]     partial, trial;
    logic [WIDTH-1:0]   step_rem, step_quo;
    logic [WIDTH-1:0]   rem_fix, quo_fix;

    assign abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // Shift-then-compare in one step; the WIDTH+1-bit trial keeps the bit
    // shifted out of the partial remainder, so divisors above 2^(WIDTH-1) work.
    always_comb begin
        partial  = {rem_q, quo_q[WIDTH-1]};
        trial    = partial - {1'b0, divisor_q};
        step_rem = trial[WIDTH] ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
        step_quo = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        quo_fix  = (signed_q && (sign1_q != sign2_q)) ? -step_quo : step_quo;
        rem_fix  = (signed_q && sign1_q) ? -step_rem : step_rem;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        signed_d  = signed_q;
        sign1_d   = sign1_q;
        sign2_d   = sign2_q;
        result_d  = result_q;
        if (annul_i) begin
            state_d  = DivFree;
            cnt_d    = '0;
            result_d = '0;
        end else begin
            unique case (state_q)
                DivFree: begin
                    if (start_i == DivStart) begin
                        if (opdata2_i == '0) begin
                            state_d = DivByZero;
                        end else begin
                            state_d   = DivOn;
                            cnt_d     = '0;
                            rem_d     = '0;
                            quo_d     = abs1;
                            divisor_d = abs2;
                            signed_d  = signed_div_i;
                            sign1_d   = opdata1_i[WIDTH-1];
                            sign2_d   = opdata2_i[WIDTH-1];
                        end
                    end
                end
                DivByZero: begin
                    state_d  = DivEnd;
                    result_d = '0;
                end
                DivOn: begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + DivCntW'(1);
                    if (cnt_q == CntLast) begin
                        state_d  = DivEnd;
                        result_d = {rem_fix, quo_fix};
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        state_d  = DivFree;
                        result_d = '0;
                    end
                end
                default: state_d = DivFree;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            signed_q  <= 1'b0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            signed_q  <= signed_d;
            sign1_q   <= sign1_d;
            sign2_q   <= sign2_d;
            result_q  <= result_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = (state_q == DivEnd) ? DivResultReady : DivResultNotReady;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: arithmetic reference model plus directed vectors.
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    int checks = 0;
    int errors = 0;

    ex_div #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result from plain 64-bit arithmetic (truncating division).
    function automatic logic [63:0] golden(input logic s, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Behavioural model: accept in idle, deliver after a fixed delay, hold while start high.
    logic        m_ready = 1'b0;
    logic [63:0] m_res = '0;
    logic [63:0] m_pend = '0;
    int          m_left = 0;

    always @(posedge clk) begin
        if (rst || annul_i) begin
            m_ready = 1'b0;
            m_res   = '0;
            m_left  = 0;
        end else if (m_ready) begin
            if (!start_i) begin
                m_ready = 1'b0;
                m_res   = '0;
            end
        end else if (m_left != 0) begin
            m_left--;
            if (m_left == 0) begin
                m_ready = 1'b1;
                m_res   = m_pend;
            end
        end else if (start_i) begin
            m_left = (opdata2_i == 32'd0) ? 1 : 32;
            m_pend = golden(signed_div_i, opdata1_i, opdata2_i);
        end
    end

    always @(negedge clk) begin
        check("cyc_ready", {63'd0, ready_o}, {63'd0, m_ready});
        check("cyc_result", result_o, m_res);
    end

    // Called at posedge+1; returns at posedge+1 with start low for one edge.
    task automatic run_div(input string name, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input int exp_cyc,
                           input logic [63:0] exp_res, input int hold);
        int n;
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        n = 0;
        while (!ready_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
            end
        end
        check({name, "_latency"}, 64'(n), 64'(exp_cyc));
        check({name, "_result"}, result_o, exp_res);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({name, "_hold_ready"}, {63'd0, ready_o}, 64'd1);
            check({name, "_hold_result"}, result_o, exp_res);
        end
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_drop_ready"}, {63'd0, ready_o}, 64'd0);
        check({name, "_drop_result"}, result_o, 64'd0);
    endtask

    initial begin
        int seen;

        // Pin the reference function with hand-computed values.
        check("pin_divu_100_7", golden(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        check("pin_div_m7_2", golden(1'b1, 32'hFFFF_FFF9, 32'd2),
              {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        check("pin_div_7_m2", golden(1'b1, 32'd7, 32'hFFFF_FFFE), {32'd1, 32'hFFFF_FFFD});
        check("pin_div_ovf", golden(1'b1, 32'h8000_0000, 32'hFFFF_FFFF),
              {32'd0, 32'h8000_0000});

        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", {63'd0, ready_o}, 64'd0);
        check("reset_result", result_o, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14}, 0);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, {32'd1, 32'hFFFF_FFFD}, 0);
        run_div("divu_by0", 1'b0, 32'd1234, 32'd0, 2, 64'd0, 0);
        run_div("div_by0", 1'b1, 32'hFFFF_FFFF, 32'd0, 2, 64'd0, 0);

        // Annul at cnt=10: start accepted at E0, cnt reaches 10 after E10.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd50;
        opdata2_i    = 32'd5;
        start_i      = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) seen++;
        end
        check("annul_no_ready", 64'(seen), 64'd0);
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 33, {32'd0, 32'd3}, 0);

        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'd0, 32'h8000_0000}, 0);
        run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, {32'd0, 32'hFFFF_FFFF}, 0);
        run_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 33,
                {32'h7FFF_FFFE, 32'd1}, 0);

        // Reset in the middle of an operation.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        rst     = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ready", {63'd0, ready_o}, 64'd0);
        check("midrst_result", result_o, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_div("div_hold", 1'b1, 32'hFFFF_FF9C, 32'd7, 33, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
